// File: rtl/cpu_sequencer_pkg.sv
// Shared constants for the sequencer and the control decode: opcodes, state
// encodings, trap causes and the opcode legality check.
package cpu_sequencer_pkg;

    typedef enum logic [2:0] {
        SEQ_FETCH   = 3'd0,
        SEQ_DECODE  = 3'd1,
        SEQ_EXECUTE = 3'd2,
        SEQ_MEM     = 3'd3,
        SEQ_WB      = 3'd4,
        SEQ_HALT    = 3'd5,
        SEQ_TRAP    = 3'd6
    } seq_state_e;

    localparam logic [6:0] OP_LUI     = 7'b0110111;
    localparam logic [6:0] OP_AUIPC   = 7'b0010111;
    localparam logic [6:0] OP_JAL     = 7'b1101111;
    localparam logic [6:0] OP_JALR    = 7'b1100111;
    localparam logic [6:0] OP_BRANCH  = 7'b1100011;
    localparam logic [6:0] OP_LOAD    = 7'b0000011;
    localparam logic [6:0] OP_STORE   = 7'b0100011;
    localparam logic [6:0] OP_ALU_IMM = 7'b0010011;
    localparam logic [6:0] OP_ALU     = 7'b0110011;

    localparam logic [1:0] TRAP_NONE    = 2'b00;
    localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
    localparam logic [1:0] TRAP_IMEM    = 2'b10;
    localparam logic [1:0] TRAP_DMEM    = 2'b11;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;
    localparam int          WAIT_W   = 8;

    function automatic logic op_legal(input logic [6:0] op);
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
            OP_LOAD, OP_STORE, OP_ALU_IMM, OP_ALU: op_legal = 1'b1;
            default:                              op_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Memory handshake, halt control and status bundle between the sequencer and
// the rest of the core.
interface cpu_sequencer_if;
    logic        imemValid;
    logic [31:0] imemData;
    logic        dmemValid;
    logic        haltReq;
    logic        imemReq;
    logic        dmemReq;
    logic        dmemWe;
    logic [31:0] inst;
    logic        pcWriteEn;
    logic        regCommit;
    logic        halted;
    logic        trap;
    logic [1:0]  trapCause;
    logic [31:0] retired;

    modport master (
        input  imemValid, imemData, dmemValid, haltReq,
        output imemReq, dmemReq, dmemWe, inst, pcWriteEn, regCommit,
               halted, trap, trapCause, retired
    );

    modport slave (
        output imemValid, imemData, dmemValid, haltReq,
        input  imemReq, dmemReq, dmemWe, inst, pcWriteEn, regCommit,
               halted, trap, trapCause, retired
    );
endinterface

// File: rtl/cpu_sequencer_mem_wait_timer.sv
// Counts memory wait cycles; expired means the current wait is the last one
// allowed before a timeout.
module mem_wait_timer
    import cpu_sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_tick,
    output logic o_expired
);

    logic [WAIT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          r_cnt <= '0;
        else if (i_clear) r_cnt <= '0;
        else if (i_tick)  r_cnt <= r_cnt + 1'b1;
    end

    assign o_expired = (r_cnt == WAIT_W'(MEM_TIMEOUT));

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute/mem/writeback sequencer with memory wait
// timeouts, halt at instruction boundaries and a retired-instruction counter.
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst,
    cpu_sequencer_if.master bus
);

    seq_state_e  r_state, w_next;
    logic [31:0] r_inst, r_retired;
    logic [1:0]  r_trapCause, w_trapCause;
    logic        r_started;
    logic        w_clear, w_tick, w_expired;
    logic        w_imemReq, w_dmemReq, w_dmemWe, w_pcWriteEn, w_regCommit;
    logic [6:0]  w_op;
    logic        w_isMem, w_noCommit;

    assign w_op       = r_inst[6:0];
    assign w_isMem    = (w_op == OP_LOAD) || (w_op == OP_STORE);
    assign w_noCommit = (w_op == OP_BRANCH) || (w_op == OP_STORE) || (r_inst[11:7] == 5'd0);

    // Counter only runs in the two waiting states, so any other state clears it.
    assign w_clear = !((r_state == SEQ_FETCH) || (r_state == SEQ_MEM));
    assign w_tick  = ((r_state == SEQ_FETCH) && r_started && !bus.imemValid) ||
                     ((r_state == SEQ_MEM) && !bus.dmemValid);

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_clear),
        .i_tick    (w_tick),
        .o_expired (w_expired)
    );

    // r_started holds FETCH idle for the cycle after reset release, keeping
    // requests low until the first edge out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= SEQ_FETCH;
            r_started <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_started <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inst      <= INST_NOP;
            r_retired   <= '0;
            r_trapCause <= TRAP_NONE;
        end else begin
            if (r_state == SEQ_FETCH && r_started && bus.imemValid) r_inst <= bus.imemData;
            if (r_state == SEQ_WB) r_retired <= r_retired + 32'd1;
            if (w_next == SEQ_TRAP && r_state != SEQ_TRAP) r_trapCause <= w_trapCause;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_trapCause = TRAP_NONE;
        w_imemReq   = 1'b0;
        w_dmemReq   = 1'b0;
        w_dmemWe    = 1'b0;
        w_pcWriteEn = 1'b0;
        w_regCommit = 1'b0;
        case (r_state)
            SEQ_FETCH: if (r_started) begin
                w_imemReq = 1'b1;
                if (bus.imemValid) w_next = SEQ_DECODE;
                else if (w_expired) begin
                    w_next      = SEQ_TRAP;
                    w_trapCause = TRAP_IMEM;
                end
            end
            SEQ_DECODE: begin
                if (op_legal(w_op)) w_next = SEQ_EXECUTE;
                else begin
                    w_next      = SEQ_TRAP;
                    w_trapCause = TRAP_ILLEGAL;
                end
            end
            SEQ_EXECUTE: w_next = w_isMem ? SEQ_MEM : SEQ_WB;
            SEQ_MEM: begin
                w_dmemReq = 1'b1;
                w_dmemWe  = (w_op == OP_STORE);
                if (bus.dmemValid) w_next = SEQ_WB;
                else if (w_expired) begin
                    w_next      = SEQ_TRAP;
                    w_trapCause = TRAP_DMEM;
                end
            end
            SEQ_WB: begin
                w_pcWriteEn = 1'b1;
                w_regCommit = !w_noCommit;
                w_next      = bus.haltReq ? SEQ_HALT : SEQ_FETCH;
            end
            SEQ_HALT: if (!bus.haltReq) w_next = SEQ_FETCH;
            SEQ_TRAP: w_next = SEQ_TRAP;
            default:  w_next = SEQ_TRAP;
        endcase
    end

    assign bus.imemReq   = w_imemReq;
    assign bus.dmemReq   = w_dmemReq;
    assign bus.dmemWe    = w_dmemWe;
    assign bus.pcWriteEn = w_pcWriteEn;
    assign bus.regCommit = w_regCommit;
    assign bus.inst      = r_inst;
    assign bus.halted    = (r_state == SEQ_HALT);
    assign bus.trap      = (r_state == SEQ_TRAP);
    assign bus.trapCause = r_trapCause;
    assign bus.retired   = r_retired;

endmodule
